// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART byte serializer among N_REQ clients.
// A grant is held for a whole packet. It is released early when MAX_PKT bytes
// have been sent, and it is revoked (pkt_abort) on a client stall or when the
// serializer never raises busy.
module uart_tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_PKT  = 16,
    parameter int STALL_TO = 64,
    parameter int BUSY_TO  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic [N_REQ-1:0]   grant,
    output logic               pkt_abort
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SEND      = 3'd1;
    localparam logic [2:0] S_LAUNCH    = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    localparam logic [7:0]       MAX_PKT_B  = 8'(MAX_PKT);
    localparam logic [7:0]       STALL_LAST = 8'(STALL_TO - 1);
    localparam logic [3:0]       BUSY_LAST  = 4'(BUSY_TO - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0   = N_REQ'(1);

    logic [2:0]    state;
    logic [PW-1:0] rr_ptr;      // last winner; doubles as index of current owner
    logic [7:0]    byte_cnt;
    logic [7:0]    stall_cnt;
    logic [3:0]    busy_cnt;
    logic          last_flag;

    logic [7:0]    data_arr [N_REQ];
    logic          win_found;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] cand;

    // Split the flat data bus into one byte per client.
    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign data_arr[i] = req_data[8*i +: 8];
    end

    // Owner view: rr_ptr equals the granted index for the whole grant.
    logic       g_valid;
    logic       g_last;
    logic [7:0] g_data;
    assign g_valid = req_valid[rr_ptr];
    assign g_last  = req_last[rr_ptr];
    assign g_data  = data_arr[rr_ptr];

    assign tx_start  = (state == S_LAUNCH);
    assign req_ready = (state == S_SEND && !tx_busy) ? grant : '0;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = PW'((int'(rr_ptr) + k) % N_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Grant / byte sequencing FSM with stall and busy watchdogs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            grant     <= '0;
            rr_ptr    <= PW'(N_REQ - 1);
            byte_cnt  <= '0;
            stall_cnt <= '0;
            busy_cnt  <= '0;
            last_flag <= 1'b0;
            tx_data   <= '0;
            pkt_abort <= 1'b0;
        end else begin
            pkt_abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        grant     <= ONE_HOT0 << win_idx;
                        rr_ptr    <= win_idx;
                        byte_cnt  <= '0;
                        stall_cnt <= '0;
                        state     <= S_SEND;
                    end else begin
                        grant <= '0;
                    end
                end
                S_SEND: begin
                    // A busy serializer (e.g. after reset) freezes both handshake and stall timer.
                    if (!tx_busy) begin
                        if (g_valid) begin
                            tx_data   <= g_data;
                            last_flag <= g_last || (byte_cnt + 8'd1 == MAX_PKT_B);
                            byte_cnt  <= byte_cnt + 8'd1;
                            stall_cnt <= '0;
                            state     <= S_LAUNCH;
                        end else if (stall_cnt == STALL_LAST) begin
                            pkt_abort <= 1'b1;
                            grant     <= '0;
                            state     <= S_IDLE;
                        end else begin
                            stall_cnt <= stall_cnt + 8'd1;
                        end
                    end
                end
                S_LAUNCH: begin
                    busy_cnt <= '0;
                    state    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (busy_cnt == BUSY_LAST) begin
                        pkt_abort <= 1'b1;
                        grant     <= '0;
                        state     <= S_IDLE;
                    end else begin
                        busy_cnt <= busy_cnt + 4'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_flag) begin
                            grant <= '0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_SEND;
                        end
                    end
                end
                default: begin
                    grant <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a simple serializer
// model and a packet-level reference model of the arbitration rules.
module tb_uart_tx_arbiter;

    localparam int N = 4, MAXP = 16, STO = 64, BTO = 8, QD = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy = 1'b0;
    logic [N-1:0]   grant;
    logic           pkt_abort;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .MAX_PKT(MAXP), .STALL_TO(STO), .BUSY_TO(BTO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
        .tx_start(tx_start), .tx_busy(tx_busy), .grant(grant), .pkt_abort(pkt_abort)
    );

    int cmp_cnt = 0, fail_cnt = 0;

    // Per-requester byte queues: {last, data}
    logic [8:0] rq [N][QD];
    int         rh [N];
    int         rt [N];

    // Reference model output
    int         exp_req [$];
    logic [7:0] exp_dat [$];
    int         exp_ab;

    // Observations
    logic [N-1:0] obs_gnt [$];
    logic [7:0]   obs_dat [$];
    logic [N-1:0] eg;

    int   cyc = 0, start_cyc = 0, fall_cyc = 0, abort_from_start = 0, abort_from_fall = 0;
    int   n_abort = 0, stab_err = 0, abort_gnt_err = 0, ser_rem = 0, frame_len = 4;
    bit   busy_en = 1'b1, ser_start = 1'b0, prev_busy = 1'b0, cap_ok = 1'b0, tmo = 1'b0;
    logic [7:0] cap = '0;

    task automatic push(input int r, input logic [7:0] d, input bit lst);
        rq[r][rt[r]] = {lst, d};
        rt[r]++;
    endtask

    // One clock: drive at negedge, sample 1ns later, advance the models.
    task automatic tick();
        @(negedge clk);
        tx_busy = busy_en && (ser_rem > 0);
        for (int i = 0; i < N; i++) begin
            if (rh[i] < rt[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rq[i][rh[i]][7:0];
                req_last[i]        = rq[i][rh[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
        #1;
        if (tx_start) begin
            obs_gnt.push_back(grant);
            obs_dat.push_back(tx_data);
            cap = tx_data; cap_ok = 1'b1; start_cyc = cyc; ser_start = busy_en;
        end
        if (tx_busy && cap_ok && tx_data !== cap) stab_err++;
        if (pkt_abort) begin
            n_abort++;
            abort_from_start = cyc - start_cyc;
            abort_from_fall  = cyc - fall_cyc;
            if (grant !== '0) abort_gnt_err++;
        end
        if (prev_busy && !tx_busy) fall_cyc = cyc;
        prev_busy = tx_busy;
        for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) rh[i]++;
        if (ser_rem > 0) ser_rem--;
        if (ser_start) begin ser_rem = frame_len; ser_start = 1'b0; end
        cyc++;
    endtask

    // Tick until all queues drained and the arbiter is idle; tmo flags budget overrun.
    task automatic run(input int budget);
        int k, done;
        bit empty;
        k = 0; done = 0; tmo = 1'b0;
        while (done < 3) begin
            if (k >= budget) begin tmo = 1'b1; break; end
            tick(); k++;
            empty = 1'b1;
            for (int i = 0; i < N; i++) if (rh[i] < rt[i]) empty = 1'b0;
            if (empty && grant == '0 && !tx_busy && ser_rem == 0) done++; else done = 0;
        end
    endtask

    // Packet-level reference: round-robin over non-empty queues; a grant ends on
    // last, on MAX_PKT bytes, or with an abort when the client runs dry or the
    // serializer never answers.
    task automatic build_model(input bit ben);
        int h [N];
        int rr, w, cnt;
        logic [8:0] e;
        exp_req.delete(); exp_dat.delete(); exp_ab = 0;
        for (int i = 0; i < N; i++) h[i] = rh[i];
        rr = N - 1;
        while (1) begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && h[(rr + k) % N] < rt[(rr + k) % N]) w = (rr + k) % N;
            if (w < 0) break;
            rr = w; cnt = 0;
            while (1) begin
                e = rq[w][h[w]]; h[w]++; cnt++;
                exp_req.push_back(w); exp_dat.push_back(e[7:0]);
                if (!ben) begin exp_ab++; break; end
                if (e[8] || cnt == MAXP) break;
                if (h[w] == rt[w]) begin exp_ab++; break; end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
        for (int i = 0; i < N; i++) begin rh[i] = 0; rt[i] = 0; end
        ser_rem = 0; ser_start = 1'b0; prev_busy = 1'b0; cap_ok = 1'b0; busy_en = 1'b1;
        obs_gnt.delete(); obs_dat.delete();
        n_abort = 0; stab_err = 0; abort_gnt_err = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; tx_busy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        cmp_cnt++; if (grant !== '0) begin fail_cnt++; $display("FAIL reset_grant: got %b need 0", grant); end
        cmp_cnt++; if (req_ready !== '0) begin fail_cnt++; $display("FAIL reset_ready: got %b need 0", req_ready); end
        cmp_cnt++; if (tx_start !== 1'b0) begin fail_cnt++; $display("FAIL reset_start: got %b need 0", tx_start); end
        cmp_cnt++; if (tx_data !== 8'h00) begin fail_cnt++; $display("FAIL reset_data: got %h need 00", tx_data); end
        cmp_cnt++; if (pkt_abort !== 1'b0) begin fail_cnt++; $display("FAIL reset_abort: got %b need 0", pkt_abort); end
    endtask

    task automatic test_single_packet();
        do_reset(); frame_len = 4;
        push(0, 8'h55, 0); push(0, 8'hAA, 0); push(0, 8'h0F, 1);
        build_model(1'b1);
        run(2000);
        cmp_cnt++; if (tmo) begin fail_cnt++; $display("FAIL single_timeout: run did not drain"); end
        cmp_cnt++; if (obs_dat.size() !== 3) begin fail_cnt++; $display("FAIL single_count: got %0d need 3", obs_dat.size()); end
        for (int i = 0; i < exp_dat.size() && i < obs_dat.size(); i++) begin
            eg = '0; eg[exp_req[i]] = 1'b1;
            cmp_cnt++;
            if (obs_gnt[i] !== eg || obs_dat[i] !== exp_dat[i]) begin
                fail_cnt++; $display("FAIL single_byte%0d: got g=%b d=%h need g=%b d=%h", i, obs_gnt[i], obs_dat[i], eg, exp_dat[i]);
            end
        end
        cmp_cnt++; if (grant !== '0) begin fail_cnt++; $display("FAIL single_release: got %b need 0", grant); end
        cmp_cnt++; if (stab_err !== 0) begin fail_cnt++; $display("FAIL single_stable: got %0d changes need 0", stab_err); end
    endtask

    task automatic test_round_robin();
        int ord [5] = '{0, 1, 2, 3, 0};
        do_reset(); frame_len = 3;
        for (int r = 0; r < N; r++) begin push(r, 8'(8'h10 + r), 1); push(r, 8'(8'h20 + r), 1); end
        build_model(1'b1);
        run(2000);
        cmp_cnt++; if (tmo) begin fail_cnt++; $display("FAIL rr_timeout: run did not drain"); end
        cmp_cnt++; if (obs_dat.size() !== exp_dat.size()) begin fail_cnt++; $display("FAIL rr_count: got %0d need %0d", obs_dat.size(), exp_dat.size()); end
        for (int i = 0; i < 5 && i < obs_gnt.size(); i++) begin
            eg = '0; eg[ord[i]] = 1'b1;
            cmp_cnt++; if (obs_gnt[i] !== eg) begin fail_cnt++; $display("FAIL rr_order%0d: got %b need %b", i, obs_gnt[i], eg); end
        end
        for (int i = 0; i < exp_dat.size() && i < obs_dat.size(); i++) begin
            eg = '0; eg[exp_req[i]] = 1'b1;
            cmp_cnt++;
            if (obs_gnt[i] !== eg || obs_dat[i] !== exp_dat[i]) begin
                fail_cnt++; $display("FAIL rr_byte%0d: got g=%b d=%h need g=%b d=%h", i, obs_gnt[i], obs_dat[i], eg, exp_dat[i]);
            end
        end
    endtask

    task automatic test_max_pkt();
        do_reset(); frame_len = 2;
        for (int b = 0; b < 20; b++) push(1, 8'($urandom), b == 19);
        for (int b = 0; b < 3; b++) push(2, 8'($urandom), b == 2);
        build_model(1'b1);
        run(4000);
        cmp_cnt++; if (tmo) begin fail_cnt++; $display("FAIL maxpkt_timeout: run did not drain"); end
        cmp_cnt++; if (obs_dat.size() !== 23) begin fail_cnt++; $display("FAIL maxpkt_count: got %0d need 23", obs_dat.size()); end
        for (int i = 0; i < exp_dat.size() && i < obs_dat.size(); i++) begin
            eg = '0; eg[exp_req[i]] = 1'b1;
            cmp_cnt++;
            if (obs_gnt[i] !== eg || obs_dat[i] !== exp_dat[i]) begin
                fail_cnt++; $display("FAIL maxpkt_byte%0d: got g=%b d=%h need g=%b d=%h", i, obs_gnt[i], obs_dat[i], eg, exp_dat[i]);
            end
        end
        cmp_cnt++; if (n_abort !== 0) begin fail_cnt++; $display("FAIL maxpkt_aborts: got %0d need 0", n_abort); end
    endtask

    task automatic test_stall();
        do_reset(); frame_len = 4;
        push(0, 8'h5A, 0); push(1, 8'h33, 1);
        build_model(1'b1);
        run(2000);
        cmp_cnt++; if (tmo) begin fail_cnt++; $display("FAIL stall_timeout: run did not drain"); end
        cmp_cnt++; if (obs_dat.size() !== exp_dat.size()) begin fail_cnt++; $display("FAIL stall_count: got %0d need %0d", obs_dat.size(), exp_dat.size()); end
        for (int i = 0; i < exp_dat.size() && i < obs_dat.size(); i++) begin
            eg = '0; eg[exp_req[i]] = 1'b1;
            cmp_cnt++;
            if (obs_gnt[i] !== eg || obs_dat[i] !== exp_dat[i]) begin
                fail_cnt++; $display("FAIL stall_byte%0d: got g=%b d=%h need g=%b d=%h", i, obs_gnt[i], obs_dat[i], eg, exp_dat[i]);
            end
        end
        cmp_cnt++; if (n_abort !== exp_ab) begin fail_cnt++; $display("FAIL stall_aborts: got %0d need %0d", n_abort, exp_ab); end
        // busy falls (WAIT_DONE cycle), then STALL_TO idle SEND cycles, pulse one cycle later
        cmp_cnt++; if (abort_from_fall !== STO + 1) begin fail_cnt++; $display("FAIL stall_delay: got %0d need %0d", abort_from_fall, STO + 1); end
        cmp_cnt++; if (abort_gnt_err !== 0) begin fail_cnt++; $display("FAIL stall_grant: got %0d aborts with grant set need 0", abort_gnt_err); end
    endtask

    task automatic test_busy_timeout();
        do_reset(); busy_en = 1'b0;
        push(0, 8'hA1, 1); push(0, 8'hA2, 1); push(1, 8'hB1, 1);
        build_model(1'b0);
        run(2000);
        cmp_cnt++; if (tmo) begin fail_cnt++; $display("FAIL busyto_timeout: run did not drain"); end
        cmp_cnt++; if (obs_dat.size() !== 3) begin fail_cnt++; $display("FAIL busyto_count: got %0d need 3", obs_dat.size()); end
        for (int i = 0; i < exp_dat.size() && i < obs_dat.size(); i++) begin
            eg = '0; eg[exp_req[i]] = 1'b1;
            cmp_cnt++;
            if (obs_gnt[i] !== eg || obs_dat[i] !== exp_dat[i]) begin
                fail_cnt++; $display("FAIL busyto_byte%0d: got g=%b d=%h need g=%b d=%h", i, obs_gnt[i], obs_dat[i], eg, exp_dat[i]);
            end
        end
        cmp_cnt++; if (n_abort !== 3) begin fail_cnt++; $display("FAIL busyto_aborts: got %0d need 3", n_abort); end
        cmp_cnt++; if (abort_from_start !== BTO + 1) begin fail_cnt++; $display("FAIL busyto_delay: got %0d need %0d", abort_from_start, BTO + 1); end
        busy_en = 1'b1;
    endtask

    task automatic test_random();
        int np, len;
        for (int it = 0; it < 3; it++) begin
            do_reset(); frame_len = $urandom_range(1, 5);
            for (int r = 0; r < N; r++) begin
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) begin
                    len = $urandom_range(1, 20);
                    for (int b = 0; b < len; b++) push(r, 8'($urandom), b == len - 1);
                end
            end
            build_model(1'b1);
            run(6000);
            cmp_cnt++; if (tmo) begin fail_cnt++; $display("FAIL rand%0d_timeout: run did not drain", it); end
            cmp_cnt++; if (obs_dat.size() !== exp_dat.size()) begin fail_cnt++; $display("FAIL rand%0d_count: got %0d need %0d", it, obs_dat.size(), exp_dat.size()); end
            for (int i = 0; i < exp_dat.size() && i < obs_dat.size(); i++) begin
                eg = '0; eg[exp_req[i]] = 1'b1;
                cmp_cnt++;
                if (obs_gnt[i] !== eg || obs_dat[i] !== exp_dat[i]) begin
                    fail_cnt++; $display("FAIL rand%0d_byte%0d: got g=%b d=%h need g=%b d=%h", it, i, obs_gnt[i], obs_dat[i], eg, exp_dat[i]);
                end
            end
            cmp_cnt++; if (n_abort !== 0) begin fail_cnt++; $display("FAIL rand%0d_aborts: got %0d need 0", it, n_abort); end
            cmp_cnt++; if (stab_err !== 0) begin fail_cnt++; $display("FAIL rand%0d_stable: got %0d changes need 0", it, stab_err); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int k, viol;
        bit saw_wait, drained;
        do_reset(); frame_len = 10;
        push(0, 8'h11, 0); push(0, 8'h22, 1);
        k = 0;
        while (!tx_busy && k < 200) begin tick(); k++; end
        tick(); tick();
        cmp_cnt++; if (tx_busy !== 1'b1) begin fail_cnt++; $display("FAIL rstmid_setup: got busy=%b need 1", tx_busy); end
        rst_n = 1'b0; cap_ok = 1'b0;
        #1;
        cmp_cnt++; if (grant !== '0) begin fail_cnt++; $display("FAIL rstmid_grant: got %b need 0", grant); end
        cmp_cnt++; if (tx_start !== 1'b0) begin fail_cnt++; $display("FAIL rstmid_start: got %b need 0", tx_start); end
        cmp_cnt++; if (req_ready !== '0) begin fail_cnt++; $display("FAIL rstmid_ready: got %b need 0", req_ready); end
        obs_gnt.delete(); obs_dat.delete();
        tick();
        rst_n = 1'b1;
        viol = 0; saw_wait = 1'b0; drained = 1'b0; k = 0;
        while (k < 400 && !drained) begin
            tick(); k++;
            if (tx_busy && req_ready !== '0) viol++;
            if (tx_busy && grant === 4'b0001 && obs_dat.size() == 0) saw_wait = 1'b1;
            drained = (rh[0] == rt[0]) && grant == '0 && ser_rem == 0;
        end
        cmp_cnt++; if (!drained) begin fail_cnt++; $display("FAIL rstmid_timeout: got no drain need drain in 400 cycles"); end
        cmp_cnt++; if (!saw_wait) begin fail_cnt++; $display("FAIL rstmid_wait: got no grant during old frame need grant held waiting"); end
        cmp_cnt++; if (viol !== 0) begin fail_cnt++; $display("FAIL rstmid_ready_busy: got %0d ready cycles while busy need 0", viol); end
        cmp_cnt++;
        if (obs_dat.size() !== 1 || obs_gnt[0] !== 4'b0001 || obs_dat[0] !== 8'h22) begin
            fail_cnt++; $display("FAIL rstmid_byte: got %0d starts first d=%h need 1 start d=22 g=0001",
                                 obs_dat.size(), (obs_dat.size() > 0) ? obs_dat[0] : 8'h00);
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_max_pkt();
        test_stall();
        test_busy_timeout();
        test_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion need finish before 90000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
